// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer request bus plus the uart_tx start/done handshake.
// The master modport belongs to the arbiter. The slave modport is for the producers and serializer side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;

    modport master (
        input  req, req_data, tx_done_tick,
        output ack, grant, busy, tx_start, tx_din
    );

    modport slave (
        output req, req_data, tx_done_tick,
        input  ack, grant, busy, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer between NREQ byte producers.
// Each grant sends one byte and acknowledges the owning requester when the byte's
// tx_done_tick arrives.
// Optional macro UART_ARB_HDR_EN: each grant first sends a header byte (HDR_BASE | winner)
// and then the data byte.
module uart_tx_arbiter #(
    parameter int              NREQ     = 4,
    parameter int              DBIT     = 8,
    parameter logic [DBIT-1:0] HDR_BASE = 'hA0
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.master  bus
);
    localparam int            IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    // Configuration sanity: requester count range and header base alignment
    if (NREQ < 2 || NREQ > 8 || HDR_BASE[IW-1:0] != '0) begin : g_cfg_err
        $error("uart_tx_arbiter: NREQ must be 2..8 and HDR_BASE low index bits must be 0");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
`ifdef UART_ARB_HDR_EN
        S_HDR_WAIT  = 2'd1,
`endif
        S_DATA_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_grant;
    logic            r_tx_start;
    logic [DBIT-1:0] r_tx_din;
`ifdef UART_ARB_HDR_EN
    logic [DBIT-1:0] r_data;
`endif

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic [DBIT-1:0] w_data;
    logic [NREQ-1:0] w_onehot;

    // The requester being acked this cycle is not eligible, so it cannot be re-granted in its ack cycle
    assign w_elig   = bus.req & ~r_ack;
    assign w_data   = bus.req_data[w_win*DBIT +: DBIT];
    assign w_onehot = NREQ'(1) << w_win;

    // Round-robin search starting one past the pointer, with explicit wrap at NREQ-1
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == LAST) ? '0 : w_idx + ONE;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Grant FSM with registered ack/grant/tx_start/tx_din; a tx_done_tick in IDLE is ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= LAST;
            r_win      <= '0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_tx_start <= 1'b0;
            r_tx_din   <= '0;
`ifdef UART_ARB_HDR_EN
            r_data     <= '0;
`endif
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_onehot;
                        r_ptr      <= w_win;
                        r_win      <= w_win;
                        r_tx_start <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        r_tx_din   <= HDR_BASE | DBIT'(w_win);
                        r_data     <= w_data;
                        r_state    <= S_HDR_WAIT;
`else
                        r_tx_din   <= w_data;
                        r_state    <= S_DATA_WAIT;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                S_HDR_WAIT: begin
                    if (bus.tx_done_tick) begin
                        r_tx_din   <= r_data;
                        r_tx_start <= 1'b1;
                        r_state    <= S_DATA_WAIT;
                    end
                end
`endif
                S_DATA_WAIT: begin
                    if (bus.tx_done_tick) begin
                        r_ack[r_win] <= 1'b1;
                        r_grant      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.grant    = r_grant;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_din   = r_tx_din;
    assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NREQ byte producers.
- Round-robin grant; one byte per grant; per-requester acknowledge.
- Drives the serializer's tx_start/tx_din and consumes its tx_done_tick.
- Sits between the system-side producers (status, debug, command responses) and uart_tx.

Parameters:
NREQ, 4, number of requesters (2..8)
DBIT, 8, data bits per byte; must equal the serializer's DBIT
HDR_BASE, 8'hA0, header byte base (used only with UART_ARB_HDR_EN); low $clog2(NREQ) bits must be 0

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level; held until matching ack
req_data  input  NREQ*DBIT  requester i byte at [i*DBIT +: DBIT]
ack  output  NREQ  one-cycle pulse: requester's byte fully transmitted
grant  output  NREQ  one-hot owner while a transfer is in flight, else 0
busy  output  1  high in any non-IDLE state
tx_start  output  1  one-cycle pulse to uart_tx
tx_din  output  DBIT  byte to uart_tx, held stable from tx_start until tx_done_tick
tx_done_tick  input  1  end-of-stop-bit pulse from uart_tx

Behaviour:
- Everything clocked on posedge clk. Reset asserts immediately on negedge reset_n.
- Reset values:
  - state IDLE; ack, grant, tx_start, tx_din, busy all 0.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - uart_tx shares reset_n.
- Reset mid-transfer abandons the byte: no ack is issued, and the requester keeps req high to retry.
- States: IDLE, HDR_WAIT (header builds only), DATA_WAIT.
- IDLE:
  - Eligible set = req with the requester whose ack is high this cycle masked out.
  - If the set is nonempty, pick the first eligible index searching pointer+1, pointer+2, ... with wrap modulo NREQ.
  - Sample req_data of the winner this cycle.
  - Next edge: grant=onehot(winner), pointer=winner, tx_din=sampled byte, tx_start=1, state=DATA_WAIT (HDR_WAIT in header build).
  - Latency: req seen in cycle N gives tx_start/grant in cycle N+1.
- DATA_WAIT:
  - tx_start is high only in the first cycle.
  - On tx_done_tick, next edge: ack[winner]=1 for one cycle, grant=0, state=IDLE.
- Back-to-back: IDLE re-arbitrates in the ack cycle.
  - Minimum spacing from tx_done_tick to next tx_start is 2 cycles.
  - The just-acked requester is not re-granted in its ack cycle. It may present its next byte from the following cycle.
- Requester protocol:
  - req_data must be stable while req is high.
  - Dropping req before grant withdraws the byte; no ack is issued.
  - Dropping req after grant does not abort the transfer; ack is still issued.
- tx_done_tick outside *_WAIT states is ignored, with no state or output change.
- tx_start is never issued while a transfer is outstanding.
- Winner index width is $clog2(NREQ); pointer wrap from NREQ-1 to 0 is explicit, with no out-of-range index.

Optional Feature:
Macro UART_ARB_HDR_EN.
- Defined: each grant sends two bytes.
  - IDLE→HDR_WAIT with tx_din = HDR_BASE | winner and tx_start=1. The data byte is captured at grant into an internal register.
  - On tx_done_tick in HDR_WAIT: next edge tx_din=data byte, tx_start=1, state=DATA_WAIT.
  - Ack only after the data byte's tx_done_tick.
  - grant is held across both bytes.
- Not defined: HDR_WAIT does not exist and HDR_BASE is unused. One byte per grant.

Test Plan:
- Single requester: req[0]=1, data 8'h55; model pulses tx_done_tick 5 cycles after tx_start.
  → exactly one tx_start; tx_din=8'h55 held until done; ack[0] one cycle after done; grant returns to 0; no second tx_start while req[0] is still high in the ack cycle.
- All four requesters from reset, data 8'h10/11/12/13, each dropping req after ack.
  → tx_din sequence 10,11,12,13; one ack each in order 0,1,2,3; 2-cycle done→start spacing.
- Fairness: req[1] and req[3] held high permanently.
  → grant order 1,3,1,3,…; neither requester is ever served twice in succession.
- reset_n pulsed low mid DATA_WAIT for requester 2, with req[2] kept high.
  → outputs 0 immediately, no ack[2]; after release, a fresh tx_start with requester 2's byte and one ack.
- Spurious tx_done_tick in IDLE with req=0, then in the first DATA_WAIT cycle of a real transfer.
  → no ack from the IDLE pulse; the DATA_WAIT pulse completes the transfer normally.
- With UART_ARB_HDR_EN, NREQ=4: req[3]=1, data 8'h7E.
  → tx_din 8'hA3 then 8'h7E; two tx_start pulses; grant=4'b1000 throughout; single ack[3] after the second done.
